jtcps_pal_dma: RTL and testbench



---
 rtl/jtcps_pal_dma.sv | 191 +++++++++++++++++++
 tb/tb_jtcps_pal_dma.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcps_pal_dma.sv
// Palette-copy DMA for the CPS colour mixer.
// Pulls enabled palette pages from VRAM into the mixer palette RAM.
`timescale 1ns/1ps
module jtcps_pal_dma #(
   parameter int  PAGES   = 6,
   parameter int  PAGE_AW = 9,
   parameter int  VRAM_AW = 17,
   parameter int  PACKED  = 1,
   localparam int PW      = $clog2(PAGES)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pal_copy,
   input  logic [VRAM_AW-1:0]    pal_base,
   input  logic [PAGES-1:0]      pal_page_en,
   output logic                  busreq,
   input  logic                  busack,
   output logic [VRAM_AW-1:0]    vram_addr,
   output logic                  vram_cs,
   input  logic [15:0]           vram_data,
   input  logic                  vram_ok,
   output logic                  pal_we,
   output logic [PW+PAGE_AW-1:0] pal_waddr,
   output logic [15:0]           pal_wdata,
   output logic                  busy,
   output logic                  done
);

   localparam int PGW = PW + 1;
   localparam int MW  = 2**PW;

   typedef enum logic [2:0] {
      IDLE, REQ, NEXT, WAIT, READ, FIN, HOLD
   } state_t;

   state_t               state, state_d;
   logic [PAGES-1:0]     mask, mask_d;
   logic [MW-1:0]        mask_x;
   logic [VRAM_AW-1:0]   base, base_d, base_in;
   logic [VRAM_AW-1:0]   src_addr, vram_addr_d;
   logic [PGW-1:0]       page, page_d, src, src_d;
   logic [PAGE_AW-1:0]   entry, entry_d;
   logic                 pending, pending_d;
   logic                 busreq_d, vram_cs_d;
   logic                 pal_we_d, done_d;
   logic [PW+PAGE_AW-1:0] pal_waddr_d;
   logic [15:0]          pal_wdata_d;
   logic                 page_end, page_sel;
   logic                 unused_base;

   // Source pages are always page aligned.
   assign base_in     = {pal_base[VRAM_AW-1:PAGE_AW], {PAGE_AW{1'b0}}};
   assign unused_base = ^pal_base[PAGE_AW-1:0];
   assign mask_x      = MW'(mask);
   assign page_end    = page == PGW'(PAGES);
   assign page_sel    = mask_x[page[PW-1:0]];
   assign src_addr    = base + (VRAM_AW'(src) << PAGE_AW);
   assign busy        = state != IDLE;

   always_comb begin
      state_d     = state;
      mask_d      = mask;
      base_d      = base;
      page_d      = page;
      src_d       = src;
      entry_d     = entry;
      pending_d   = pending | (pal_copy & (state != IDLE));
      busreq_d    = busreq;
      vram_addr_d = vram_addr;
      vram_cs_d   = vram_cs;
      pal_we_d    = 1'b0;
      pal_waddr_d = pal_waddr;
      pal_wdata_d = pal_wdata;
      done_d      = 1'b0;
      unique case (state)
         IDLE: if (pal_copy) begin
            mask_d = pal_page_en;
            base_d = base_in;
            page_d = '0;
            src_d  = '0;
            if (pal_page_en == '0) begin
               done_d = 1'b1;
            end else begin
               busreq_d = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: if (busack) state_d = NEXT;
         NEXT: begin
            if (page_end) begin
               busreq_d  = 1'b0;
               vram_cs_d = 1'b0;
               state_d   = FIN;
            end else if (!page_sel) begin
               page_d = page + 1'b1;
               if (PACKED == 0) src_d = src + 1'b1;
            end else begin
               entry_d     = '0;
               vram_addr_d = src_addr;
               vram_cs_d   = 1'b1;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (!busack) begin
               vram_cs_d = 1'b0;
               state_d   = HOLD;
            end else begin
               state_d = READ;
            end
         end
         // Data coinciding with bus loss is dropped; the entry is re-read.
         READ: begin
            if (!busack) begin
               vram_cs_d = 1'b0;
               state_d   = HOLD;
            end else if (vram_ok) begin
               pal_we_d    = 1'b1;
               pal_waddr_d = {page[PW-1:0], entry};
               pal_wdata_d = vram_data;
               if (&entry) begin
                  page_d    = page + 1'b1;
                  src_d     = src + 1'b1;
                  vram_cs_d = 1'b0;
                  state_d   = NEXT;
               end else begin
                  entry_d     = entry + 1'b1;
                  vram_addr_d = vram_addr + 1'b1;
                  state_d     = WAIT;
               end
            end
         end
         HOLD: begin
            if (busack) begin
               vram_cs_d = 1'b1;
               state_d   = WAIT;
            end
         end
         FIN: begin
            pending_d = 1'b0;
            if (pending | pal_copy) begin
               mask_d   = pal_page_en;
               base_d   = base_in;
               page_d   = '0;
               src_d    = '0;
               busreq_d = 1'b1;
               state_d  = REQ;
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mask      <= '0;
         base      <= '0;
         page      <= '0;
         src       <= '0;
         entry     <= '0;
         pending   <= 1'b0;
         busreq    <= 1'b0;
         vram_addr <= '0;
         vram_cs   <= 1'b0;
         pal_we    <= 1'b0;
         pal_waddr <= '0;
         pal_wdata <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         mask      <= mask_d;
         base      <= base_d;
         page      <= page_d;
         src       <= src_d;
         entry     <= entry_d;
         pending   <= pending_d;
         busreq    <= busreq_d;
         vram_addr <= vram_addr_d;
         vram_cs   <= vram_cs_d;
         pal_we    <= pal_we_d;
         pal_waddr <= pal_waddr_d;
         pal_wdata <= pal_wdata_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_jtcps_pal_dma.sv
// Scoreboard bench for jtcps_pal_dma: packed and sparse instances
// share stimulus; each has its own VRAM responder and write queue.
`timescale 1ns/1ps
module tb_jtcps_pal_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic        pal_copy;
   logic [16:0] pal_base;
   logic [5:0]  pal_page_en;
   logic        busack;

   logic        busreq[2];
   logic        vram_cs[2];
   logic [16:0] vram_addr[2];
   logic [15:0] vram_data[2] = '{16'h0, 16'h0};
   logic        vram_ok[2]   = '{1'b0, 1'b0};
   logic        pal_we[2];
   logic [11:0] pal_waddr[2];
   logic [15:0] pal_wdata[2];
   logic        busy[2];
   logic        done[2];

   logic [27:0] exp_q[2][$];
   int n_pass = 0, n_tot = 0;
   int lat_max = 0;
   int done_cnt[2] = '{0, 0}, we_cnt[2] = '{0, 0}, dip_cnt[2] = '{0, 0};
   int s_done[2], s_we[2], s_dip[2];

   always #5 clk = ~clk;

   // Instance 0 packs sources, instance 1 maps source page = dest page.
   for (genvar k = 0; k < 2; k++) begin : g
      jtcps_pal_dma #(
         .PAGES(6), .PAGE_AW(9), .VRAM_AW(17), .PACKED(1 - k)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .pal_copy    (pal_copy),
         .pal_base    (pal_base),
         .pal_page_en (pal_page_en),
         .busreq      (busreq[k]),
         .busack      (busack),
         .vram_addr   (vram_addr[k]),
         .vram_cs     (vram_cs[k]),
         .vram_data   (vram_data[k]),
         .vram_ok     (vram_ok[k]),
         .pal_we      (pal_we[k]),
         .pal_waddr   (pal_waddr[k]),
         .pal_wdata   (pal_wdata[k]),
         .busy        (busy[k]),
         .done        (done[k])
      );
   end

   function automatic logic [15:0] vdat(input logic [16:0] a);
      logic [31:0] x;
      x = {15'd0, a} * 32'd40503;
      return x[23:8] ^ a[15:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
   endtask

   // VRAM: data for the current address after a random latency.
   task automatic vram_model();
      int cnt[2];
      int need[2];
      logic [16:0] last[2];
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            if (vram_cs[k] && vram_addr[k] == last[k]) begin
               cnt[k]++;
            end else begin
               cnt[k]  = 0;
               need[k] = $urandom_range(0, lat_max);
            end
            last[k] = vram_addr[k];
            if (vram_cs[k] && cnt[k] >= need[k]) begin
               vram_ok[k]   <= 1'b1;
               vram_data[k] <= vdat(vram_addr[k]);
            end else begin
               vram_ok[k]   <= 1'b0;
               vram_data[k] <= 16'($urandom);
            end
         end
      end
   endtask

   task automatic monitor();
      logic [27:0] e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (pal_we[k]) begin
               we_cnt[k]++;
               if (exp_q[k].size() == 0) begin
                  chk($sformatf("extra_write%0d", k), 1, 0);
               end else begin
                  e = exp_q[k].pop_front();
                  chk($sformatf("write%0d", k),
                      32'({pal_waddr[k], pal_wdata[k]}), 32'(e));
               end
            end
            if (done[k]) begin
               done_cnt[k]++;
               chk($sformatf("done_idle%0d", k), busy[k], 0);
            end
            if (busy[k] && !busreq[k]) dip_cnt[k]++;
            if (vram_cs[k]) chk($sformatf("cs_busreq%0d", k), busreq[k], 1);
         end
      end
   endtask

   // Reference: walk enabled pages in order, entries 0..511 each.
   task automatic push_exp(input logic [5:0] m, input logic [16:0] b);
      int s, src;
      logic [16:0] a;
      for (int k = 0; k < 2; k++) begin
         s = 0;
         for (int p = 0; p < 6; p++) begin
            if (m[p]) begin
               src = (k == 0) ? s : p;
               for (int e = 0; e < 512; e++) begin
                  a = 17'(int'({b[16:9], 9'd0}) + src * 512 + e);
                  exp_q[k].push_back({12'(p * 512 + e), vdat(a)});
               end
               s++;
            end
         end
      end
   endtask

   task automatic snap();
      for (int k = 0; k < 2; k++) begin
         s_done[k] = done_cnt[k];
         s_we[k]   = we_cnt[k];
         s_dip[k]  = dip_cnt[k];
      end
   endtask

   task automatic pulse_copy(input logic [5:0] m, input logic [16:0] b);
      pal_page_en = m;
      pal_base    = b;
      pal_copy    = 1'b1;
      @(negedge clk);
      pal_copy = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      while ((busy[0] || busy[1]) && t < 40000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40000) chk({nm, "_timeout"}, 1, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_addr(input string nm, input logic [16:0] a);
      int t = 0;
      while (!(vram_cs[0] && vram_addr[0] == a) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) chk({nm, "_addr_timeout"}, 1, 0);
   endtask

   task automatic finish_copy(input string nm, input int n_we,
                              input int n_done, input int n_dip);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_left%0d", nm, k), exp_q[k].size(), 0);
         chk($sformatf("%s_we%0d", nm, k), we_cnt[k] - s_we[k], n_we);
         chk($sformatf("%s_done%0d", nm, k), done_cnt[k] - s_done[k], n_done);
         chk($sformatf("%s_dip%0d", nm, k), dip_cnt[k] - s_dip[k], n_dip);
         chk($sformatf("%s_busreq%0d", nm, k), busreq[k], 0);
      end
   endtask

   task automatic run_copy(input string nm, input logic [5:0] m,
                           input logic [16:0] b, input int lat);
      lat_max = lat;
      snap();
      push_exp(m, b);
      pulse_copy(m, b);
      wait_idle(nm);
      finish_copy(nm, $countones(m) * 512, 1, (m != 0) ? 1 : 0);
   endtask

   initial begin
      rst = 1'b1;
      pal_copy = 1'b0;
      pal_base = '0;
      pal_page_en = '0;
      busack = 1'b1;
      fork
         monitor();
         vram_model();
      join_none
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_ctl%0d", k),
             {busreq[k], vram_cs[k], pal_we[k], busy[k], done[k]}, 0);
         chk($sformatf("rst_addr%0d", k), vram_addr[k], 0);
         chk($sformatf("rst_wr%0d", k), {pal_waddr[k], pal_wdata[k]}, 0);
      end

      // Zero mask: immediate done, no bus request.
      snap();
      pulse_copy(6'h00, 17'h9000);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("zero_done%0d", k), done[k], 1);
         chk($sformatf("zero_busreq%0d", k), busreq[k], 0);
      end
      @(negedge clk);
      chk("zero_done_fall", {done[0], done[1]}, 0);
      finish_copy("zero", 0, 1, 0);

      // Full copy with request-to-read latency.
      lat_max = 0;
      snap();
      push_exp(6'h3F, 17'h9000);
      pulse_copy(6'h3F, 17'h9000);
      chk("full_busreq_rise", {busreq[0], vram_cs[0]}, 2'b10);
      @(negedge clk);
      chk("full_cs_c2", vram_cs[0], 0);
      @(negedge clk);
      chk("full_cs_c3", vram_cs[0], 1);
      chk("full_first_addr", vram_addr[0], 17'h9000);
      wait_idle("full");
      finish_copy("full", 3072, 1, 1);
      chk("full_last_addr0", vram_addr[0], 17'h9BFF);
      chk("full_last_addr1", vram_addr[1], 17'h9BFF);

      run_copy("sparse", 6'b100101, 17'h9000, 1);

      // Late grant, then bus lost mid-page with data on the same cycle.
      lat_max = 0;
      busack = 1'b0;
      snap();
      push_exp(6'b000011, 17'h9000);
      pulse_copy(6'b000011, 17'h9000);
      repeat (19) @(negedge clk);
      chk("late_wait", {busreq[0], vram_cs[0], busy[0]}, 3'b101);
      busack = 1'b1;
      wait_addr("drop", 17'h9010);
      @(negedge clk);
      chk("drop_ok_coincident", vram_ok[0], 1);
      busack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            chk($sformatf("gap%0d_%0d", i, k),
                {pal_we[k], busreq[k], vram_cs[k]}, 3'b010);
      end
      busack = 1'b1;
      wait_idle("drop");
      finish_copy("drop", 1024, 1, 1);

      // Three re-triggers collapse to one extra pass with the new mask.
      lat_max = 1;
      snap();
      push_exp(6'b001010, 17'h4000);
      push_exp(6'b010001, 17'h0A00);
      pulse_copy(6'b001010, 17'h4000);
      repeat (50) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         pulse_copy(6'($urandom), 17'($urandom));
         repeat (30) @(negedge clk);
      end
      pal_page_en = 6'b010001;
      pal_base    = 17'h0AAB;
      wait_idle("retrig");
      finish_copy("retrig", 2048, 1, 2);

      // Reset at entry 0x80 of page 3, then a fresh copy.
      lat_max = 0;
      snap();
      push_exp(6'h3F, 17'h2000);
      pulse_copy(6'h3F, 17'h2000);
      wait_addr("rstmid", 17'h2680);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rstmid_ctl%0d", k),
             {busreq[k], vram_cs[k], pal_we[k], busy[k], done[k]}, 0);
         chk($sformatf("rstmid_addr%0d", k), vram_addr[k], 0);
         chk($sformatf("rstmid_we%0d", k), we_cnt[k] - s_we[k], 1664);
         exp_q[k].delete();
      end
      repeat (3) @(negedge clk);
      chk("rstmid_no_done", done_cnt[0] - s_done[0], 0);
      run_copy("restart", 6'b000011, 17'h3000, 0);

      for (int i = 0; i < 3; i++)
         run_copy($sformatf("rand%0d", i), 6'($urandom_range(1, 63)),
                  17'($urandom), $urandom_range(0, 2));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
